seq_det_sched: RTL

Round-robin scheduler that shares one serial pattern detector between `N_REQ` requesters. Each granted requester's parallel frame is latched, the detector is cleared, and the frame is shifted into it MSB-first, one bit per clock. The scheduler counts detector hits over the frame and returns the count, tagged with the requester id. It sits between the requester clients and the team's two-flop Mealy detector, which has an active-high synchronous clear and a combinational `Y` output.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/seq_det_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the pattern-detector scheduler: FSM encoding and default sizes.
package seq_det_pkg;

  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_FRAME_LEN = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // sum is one bit wider than ptr so ptr+i never wraps before the modulo fold.
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    id    = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = ID_W'(sum);
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one external serial pattern detector between N_REQ requesters: latches a
// granted frame, shifts it MSB-first into the detector and reports the hit count.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter  int unsigned N_REQ     = DEF_N_REQ,
  parameter  int unsigned FRAME_LEN = DEF_FRAME_LEN,
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1),
  localparam int unsigned ID_W      = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_LEN-1:0] frame,
  input  logic                       det_y,
  output logic                       det_in,
  output logic                       det_rst,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       done,
  output logic [ID_W-1:0]            done_id,
  output logic [CNT_W-1:0]           hit_count
);

  state_t               state, state_nxt;
  logic [FRAME_LEN-1:0] shreg, shreg_nxt;
  logic [ID_W-1:0]      cur_id, cur_id_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]     hit_cnt, hit_cnt_nxt;
  logic [ID_W-1:0]      ptr, ptr_nxt;
  logic [N_REQ-1:0]     gnt_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic [ID_W-1:0]      done_id_nxt;
  logic [CNT_W-1:0]     hit_count_nxt;

  logic [N_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_valid;
  logic [FRAME_LEN-1:0] sel_frame;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .id    (arb_id),
    .valid (arb_valid)
  );

  // Frame mux for the requester the arbiter is picking this cycle.
  always_comb begin
    sel_frame = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (arb_id == ID_W'(k)) begin
        sel_frame = frame[k*FRAME_LEN +: FRAME_LEN];
      end
    end
  end

  // Detector is held cleared outside SHIFT so every frame starts from its reset state.
  assign det_in  = (state == S_SHIFT) & shreg[FRAME_LEN-1];
  assign det_rst = ~rst | (state != S_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cur_id    <= '0;
      bit_cnt   <= '0;
      hit_cnt   <= '0;
      ptr       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cur_id    <= cur_id_nxt;
      bit_cnt   <= bit_cnt_nxt;
      hit_cnt   <= hit_cnt_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      done_id   <= done_id_nxt;
      hit_count <= hit_count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    cur_id_nxt    = cur_id;
    bit_cnt_nxt   = bit_cnt;
    hit_cnt_nxt   = hit_cnt;
    ptr_nxt       = ptr;
    gnt_nxt       = gnt;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    done_id_nxt   = done_id;
    hit_count_nxt = hit_count;

    unique case (state)
      S_IDLE: begin
        if (arb_valid) begin
          shreg_nxt   = sel_frame;
          cur_id_nxt  = arb_id;
          bit_cnt_nxt = '0;
          hit_cnt_nxt = '0;
          gnt_nxt     = arb_gnt;
          busy_nxt    = 1'b1;
          state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_nxt   = shreg << 1;
        hit_cnt_nxt = hit_cnt + CNT_W'(det_y);
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        // The final bit's hit is folded straight into the reported count.
        if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
          state_nxt     = S_REPORT;
          done_nxt      = 1'b1;
          done_id_nxt   = cur_id;
          hit_count_nxt = hit_cnt + CNT_W'(det_y);
        end
      end
      S_REPORT: begin
        ptr_nxt   = (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
